// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle between a master (VIP/BFM) and the axil_reg_responder register block.
interface axil_reg_responder_if #(
    parameter int unsigned AddrWidth = 6
);
    logic [AddrWidth-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [AddrWidth-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder: NumRegs 32-bit R/W registers, independent AW/W holding buffers,
// one outstanding write and one outstanding read.
// Optional feature: define AXIL_REG_RESPONDER_WR_COUNT_EN to add a read-only counter of OKAY
// writes at word index NumRegs.
module axil_reg_responder #(
    parameter int unsigned AddrWidth = 6,
    parameter int unsigned NumRegs   = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    axil_reg_responder_if.slave bus
);
    localparam int unsigned         IdxW       = AddrWidth - 2;
    localparam logic [IdxW-1:0]     NumRegsIdx = IdxW'(NumRegs);
    localparam logic [1:0]          RespOkay   = 2'b00;
    localparam logic [1:0]          RespSlvErr = 2'b10;

    logic                      rst_done_q;
    logic                      aw_full_q, aw_full_d;
    logic [IdxW-1:0]           aw_idx_q, aw_idx_d;
    logic                      w_full_q, w_full_d;
    logic [31:0]               w_data_q, w_data_d;
    logic [3:0]                w_strb_q, w_strb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [NumRegs-1:0][31:0]  regs_q, regs_d;

    logic            aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [IdxW-1:0] rd_idx;
    logic [31:0]     rd_data;
    logic            unused_bits;

    // Address LSBs and protection bits carry no meaning for this block.
    assign unused_bits = ^{bus.awaddr[1:0], bus.araddr[1:0], bus.awprot, bus.arprot};

    assign bus.awready = rst_done_q & ~aw_full_q;
    assign bus.wready  = rst_done_q & ~w_full_q;
    assign bus.arready = rst_done_q & ~rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs  = bus.awvalid & bus.awready;
    assign w_hs   = bus.wvalid & bus.wready;
    assign ar_hs  = bus.arvalid & bus.arready;
    // Commit waits for the previous response to drain so BRESP never changes under BVALID.
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign wr_ok  = aw_idx_q < NumRegsIdx;
    assign rd_idx = bus.araddr[AddrWidth-1:2];

`ifdef AXIL_REG_RESPONDER_WR_COUNT_EN
    logic [31:0] wr_count_q, wr_count_d;

    // Count OKAY commits only; wraps naturally at 2^32.
    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && wr_ok) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end
`endif

    // Write path: buffer AW and W independently, commit when both are held and B is free.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = bus.awaddr[AddrWidth-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.wdata;
            w_strb_d = bus.wstrb;
        end
        if (bvalid_q && bus.bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RespOkay : RespSlvErr;
            for (int i = 0; i < NumRegs; i++) begin
                if (wr_ok && aw_idx_q == IdxW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: decode from current register state, so a same-edge commit is not visible.
    always_comb begin
        rd_data  = '0;
        rd_ok    = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rd_idx == IdxW'(i)) begin
                rd_data = regs_q[i];
                rd_ok   = 1'b1;
            end
        end
`ifdef AXIL_REG_RESPONDER_WR_COUNT_EN
        if (rd_idx == NumRegsIdx) begin
            rd_data = wr_count_q;
            rd_ok   = 1'b1;
        end
`endif
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && bus.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_ok ? RespOkay : RespSlvErr;
        end
    end

    // Readiness gate: rises on the first clock edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    // Buffer, response and register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            regs_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder; all inputs change and all outputs are sampled on the
// falling clock edge.
module tb_axil_reg_responder;
    localparam int unsigned AddrWidth = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;

    always #5 clk = ~clk;

    axil_reg_responder_if #(.AddrWidth(AddrWidth)) bus ();

    axil_reg_responder #(
        .AddrWidth(AddrWidth),
        .NumRegs  (4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge. lat = edges from the last handshake edge to BVALID.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] bresp, output int blat);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && cyc >= aw_dly;
            bus.wvalid  = !w_done && cyc >= w_dly;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check($sformatf("aw_w_handshake@%02h", addr), {30'd0, aw_done, w_done}, 32'd3);
        blat = 0;
        while (!bus.bvalid && blat < 50) begin
            @(negedge clk);
            blat++;
        end
        bresp = bus.bvalid ? bus.bresp : 2'bxx;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    // rlat = extra edges after the AR handshake edge before RVALID is seen (expected 0).
    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] rresp, output int rlat);
        bit done = 0;
        int cyc  = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!done && cyc < 50) begin
            done = bus.arready;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.arvalid = 1'b0;
        check($sformatf("ar_handshake@%02h", addr), {31'd0, done}, 32'd1);
        rlat = 0;
        while (!bus.rvalid && rlat < 50) begin
            @(negedge clk);
            rlat++;
        end
        data  = bus.rvalid ? bus.rdata : 'x;
        rresp = bus.rvalid ? bus.rresp : 2'bxx;
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", bus.rresp, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge clk);
        check("ready_after_first_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Sequential writes then readback
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp, lat);
            check($sformatf("seq_bresp%0d", i), resp, 2'b00);
            check($sformatf("seq_blat%0d", i), lat, 1);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), rd, resp, lat);
            check($sformatf("seq_rdata%0d", i), rd, 32'(i + 1));
            check($sformatf("seq_rresp%0d", i), resp, 2'b00);
            check($sformatf("seq_rlat%0d", i), lat, 0);
        end

        // W leads AW by 3 cycles, then AW leads W by 3 cycles
        axi_write(6'h04, 32'hA5A5_A5A5, 4'hF, 3, 0, resp, lat);
        check("w_first_blat", lat, 1);
        check("w_first_bresp", resp, 2'b00);
        axi_read(6'h04, rd, resp, lat);
        check("w_first_rdata", rd, 32'hA5A5_A5A5);
        axi_write(6'h04, 32'h5A5A_5A5A, 4'hF, 0, 3, resp, lat);
        check("aw_first_blat", lat, 1);
        axi_read(6'h04, rd, resp, lat);
        check("aw_first_rdata", rd, 32'h5A5A_5A5A);

        // Byte strobes
        axi_write(6'h08, 32'h1122_3344, 4'hF, 0, 0, resp, lat);
        axi_write(6'h08, 32'hFFFF_FFFF, 4'b0101, 0, 0, resp, lat);
        check("strb_bresp", resp, 2'b00);
        axi_read(6'h08, rd, resp, lat);
        check("strb_rdata", rd, 32'h11FF_33FF);

        // BREADY held low: second pair buffers behind the pending response
        bus.awaddr = 6'h00; bus.wdata = 32'hCAFE_0001; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (10) @(negedge clk);
        check("bhold_bvalid", bus.bvalid, 1);
        check("bhold_bresp", bus.bresp, 2'b00);
        bus.awaddr = 6'h0C; bus.wdata = 32'hCAFE_0002;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("bhold_buffers_full", {bus.awready, bus.wready}, 2'b00);
        check("bhold_bvalid_still", bus.bvalid, 1);
        axi_read(6'h0C, rd, resp, lat);
        check("bhold_no_commit_yet", rd, 32'd4);
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check("bhold_b1_cleared", bus.bvalid, 0);
        @(negedge clk);
        check("bhold_b2_valid", bus.bvalid, 1);
        check("bhold_b2_bresp", bus.bresp, 2'b00);
        check("bhold_buffers_free", {bus.awready, bus.wready}, 2'b11);
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        axi_read(6'h00, rd, resp, lat);
        check("bhold_rdata0", rd, 32'hCAFE_0001);
        axi_read(6'h0C, rd, resp, lat);
        check("bhold_rdata3", rd, 32'hCAFE_0002);

        // Out-of-range access
        axi_write(6'h20, 32'h0000_DEAD, 4'hF, 0, 0, resp, lat);
        check("oor_bresp", resp, 2'b10);
        axi_read(6'h20, rd, resp, lat);
        check("oor_rresp", resp, 2'b10);
        check("oor_rdata", rd, 32'd0);
        axi_read(6'h00, rd, resp, lat);
        check("oor_keep0", rd, 32'hCAFE_0001);
        axi_read(6'h04, rd, resp, lat);
        check("oor_keep1", rd, 32'h5A5A_5A5A);
        axi_read(6'h08, rd, resp, lat);
        check("oor_keep2", rd, 32'h11FF_33FF);
        axi_read(6'h0C, rd, resp, lat);
        check("oor_keep3", rd, 32'hCAFE_0002);

        // Index NumRegs: counter when enabled, plain out-of-range otherwise
        axi_write(6'h10, 32'h0000_0077, 4'hF, 0, 0, resp, lat);
        check("idx4_wr_bresp", resp, 2'b10);
        axi_read(6'h10, rd, resp, lat);
`ifdef AXIL_REG_RESPONDER_WR_COUNT_EN
        // 4 sequential + 2 skewed + 2 strobe + 2 held-BREADY OKAY writes
        check("cnt_rdata", rd, 32'd10);
        check("cnt_rresp", resp, 2'b00);
`else
        check("idx4_rdata", rd, 32'd0);
        check("idx4_rresp", resp, 2'b10);
`endif

        // Reset while a read response is pending
        bus.araddr = 6'h04; bus.arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("midrst_rvalid_before", bus.rvalid, 1);
        check("midrst_rdata_before", bus.rdata, 32'h5A5A_5A5A);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", bus.rvalid, 0);
        check("midrst_rdata", bus.rdata, 0);
        check("midrst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(6'h04, rd, resp, lat);
        check("midrst_reg_cleared", rd, 32'd0);
        check("midrst_rresp", resp, 2'b00);
        axi_read(6'h10, rd, resp, lat);
        check("midrst_idx4_rdata", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
